// File: rtl/ps2_keys.sv
// ps2_keys
// Receives PS/2 keyboard frames and turns four keys into level outputs.
// The raw PS/2 lines are synchronised and the clock is glitch filtered.
// Each falling edge of the filtered clock is a sample event. A frame FSM
// assembles start, data, parity and stop bits. A scan-code decoder then
// tracks the E0/F0 prefixes and drives the key outputs.
//
// Ports
//   i_clk        system clock, all state lives in this domain
//   i_rst_n      asynchronous active-low reset
//   i_ps2_clk    raw PS/2 clock (asynchronous)
//   i_ps2_data   raw PS/2 data (asynchronous)
//   o_up         high while Up-arrow (E0 75) is held
//   o_down       high while Down-arrow (E0 72) is held
//   o_space      high while Space (29) is held
//   o_enter      high while Enter (5A, non-extended) is held
//   o_byte_out   last correctly received scan-code byte
//   o_byte_valid one-cycle pulse when o_byte_out is updated
//   o_frame_err  one-cycle pulse on parity, start/stop or timeout error
module ps2_keys #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_up,
    output logic       o_down,
    output logic       o_space,
    output logic       o_enter,
    output logic [7:0] o_byte_out,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} FrameState;

    logic [1:0]    r_clkSync;
    logic [1:0]    r_dataSync;
    logic          r_filtClk;
    logic [FW-1:0] r_filtCnt;
    logic          r_sample;
    logic          r_sampleData;
    FrameState     r_state;
    FrameState     w_stateNext;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_toCnt;
    logic          w_timeout;
    logic          w_frameOk;
    logic          w_frameBad;
    logic [7:0]    r_byteOut;
    logic          r_byteValid;
    logic          r_frameErr;
    logic          r_ext;
    logic          r_brk;
    logic          r_up;
    logic          r_down;
    logic          r_space;
    logic          r_enter;

    // Two-flop synchronisers; they reset to 1 because an idle PS/2 bus is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_ps2_clk};
            r_dataSync <= {r_dataSync[0], i_ps2_data};
        end
    end

    // Clock filter: the filtered clock follows only after FILTER_LEN
    // consecutive differing samples. Any agreeing sample restarts the run.
    // The data line is captured on the same cycle the filtered clock falls.
    // That cycle is the one-cycle sample event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filtClk    <= 1'b1;
            r_filtCnt    <= '0;
            r_sample     <= 1'b0;
            r_sampleData <= 1'b1;
        end else begin
            r_sample <= 1'b0;
            if (r_clkSync[1] == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
                r_filtClk    <= r_clkSync[1];
                r_filtCnt    <= '0;
                r_sample     <= ~r_clkSync[1];
                r_sampleData <= r_dataSync[1];
            end else begin
                r_filtCnt <= r_filtCnt + FW'(1);
            end
        end
    end

    // The timeout fires only when no sample event arrives on the same cycle.
    assign w_timeout = (r_state != IDLE) && !r_sample &&
                       (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next-state. A good frame needs a 1 stop bit and an odd
    // number of ones across the data and parity bits.
    always_comb begin
        w_stateNext = r_state;
        w_frameOk   = 1'b0;
        w_frameBad  = 1'b0;
        if (w_timeout) begin
            w_stateNext = IDLE;
        end else if (r_sample) begin
            case (r_state)
                IDLE: begin
                    if (!r_sampleData) w_stateNext = DATA;
                end
                DATA: begin
                    if (r_bitCnt == 3'd7) w_stateNext = PARITY;
                end
                PARITY: begin
                    w_stateNext = STOP;
                end
                STOP: begin
                    w_stateNext = IDLE;
                    if (r_sampleData && (^{r_shift, r_parity})) w_frameOk = 1'b1;
                    else                                        w_frameBad = 1'b1;
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // Frame datapath: the shifter fills from the MSB side, so the LSB sent
    // first ends up in bit 0. Result pulses appear the cycle after the stop bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_toCnt     <= '0;
            r_byteOut   <= '0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (r_sample && !w_timeout) begin
                case (r_state)
                    IDLE:   r_bitCnt <= '0;
                    DATA: begin
                        r_shift  <= {r_sampleData, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                    PARITY: r_parity <= r_sampleData;
                    default: ;
                endcase
            end
            if (r_state == IDLE || r_sample || w_timeout) r_toCnt <= '0;
            else                                          r_toCnt <= r_toCnt + TW'(1);
            r_byteValid <= w_frameOk;
            r_frameErr  <= w_frameBad | w_timeout;
            if (w_frameOk) r_byteOut <= r_shift;
        end
    end

    // Scan-code decoder: prefixes accumulate until a non-prefix byte uses them.
    // A frame error forgets the prefixes but leaves the keys as they are.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_space <= 1'b0;
            r_enter <= 1'b0;
        end else if (r_frameErr) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byteValid) begin
            if (r_byteOut == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byteOut == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                case ({r_ext, r_byteOut})
                    9'h175:  r_up    <= ~r_brk;
                    9'h172:  r_down  <= ~r_brk;
                    9'h029:  r_space <= ~r_brk;
                    9'h05A:  r_enter <= ~r_brk;
                    default: ;
                endcase
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign o_up         = r_up;
    assign o_down       = r_down;
    assign o_space      = r_space;
    assign o_enter      = r_enter;
    assign o_byte_out   = r_byteOut;
    assign o_byte_valid = r_byteValid;
    assign o_frame_err  = r_frameErr;

endmodule

// File: doc/ps2_keys.md
PS2_KEYS -- requirements
Module: ps2_keys

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal ps2_clk samples required before the filtered PS/2 clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a PS/2 falling edge before an incomplete frame is aborted (1 ms at 100 MHz).
REQ-003 clk  input  1  system clock (100 MHz); all state is in this domain.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clk.
REQ-007 up  output  1  level; high while Up-arrow (E0 75) is held.
REQ-008 down  output  1  level; high while Down-arrow (E0 72) is held.
REQ-009 space  output  1  level; high while Space (29) is held.
REQ-010 enter  output  1  level; high while Enter (5A, non-extended) is held.
REQ-011 byte_out  output  8  last correctly received scan-code byte.
REQ-012 byte_valid  output  1  one-cycle pulse when byte_out is updated.
REQ-013 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; a sample event is a 1->0 transition of the filtered clock.
REQ-016 Frame FSM states: IDLE, DATA, PARITY, STOP; one transition per sample event only, except for timeout.
REQ-017 IDLE: sampled data 0 -> DATA with bit count 0; sampled data 1 -> remain IDLE, no error.
REQ-018 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture the parity bit -> STOP; odd parity is required (data bits plus parity bit contain an odd number of ones).
REQ-020 STOP: if stop bit is 1 and parity is correct, byte_out and byte_valid SHALL be registered on the cycle after the sample event; otherwise pulse frame_err on that cycle. In both cases -> IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYCLES clk cycles without a sample event -> IDLE, partial bits discarded, frame_err pulsed once; the counter restarts on every sample event.
REQ-022 Decoder: byte E0 sets ext flag; byte F0 sets brk flag; flags persist across bytes until a non-prefix byte arrives.
REQ-023 Non-prefix byte: if (ext, code) matches a key of REQ-007..010, that key output SHALL be set to !brk on the cycle after byte_valid; both flags are then cleared, matched or not.
REQ-024 Codes that match only with the wrong ext flag (e.g. non-extended 75, extended 5A) SHALL not affect any output.
REQ-025 frame_err SHALL clear ext and brk; key levels SHALL be unchanged.
REQ-026 Repeated make codes (typematic) SHALL leave an already-high key high with no glitch.
REQ-027 Keys are independent; several may be high simultaneously.

Reset
REQ-028 rstn low SHALL asynchronously force: FSM IDLE, bit count 0, timeout counter 0, filter and synchronizers to 1 (bus idle), ext=brk=0, all outputs 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first frame after rstn rises SHALL decode normally.

Verification
REQ-030 Send frame 29, then F0, 29 -> space=1 one cycle after the first byte_valid; space=0 after the third byte; byte_out=29 at the end.
REQ-031 Send E0,75 then E0,F0,75 -> up=1 then up=0; down, space and enter remain 0 throughout; non-extended 75 alone -> up stays 0.
REQ-032 Frame 5A with even parity -> frame_err one-cycle pulse, no byte_valid, enter=0; next valid 5A frame -> enter=1.
REQ-033 Start bit plus 4 data bits, then line idle -> frame_err exactly TIMEOUT_CYCLES (+sync/filter latency) later, FSM IDLE; following frame 29 -> space=1.
REQ-034 A 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no sample event, no byte_valid, no state change.
REQ-035 Assert rstn low after E0 and mid-frame of 75, release, send E0,75 -> all outputs 0 during reset, then up=1.
